// File: rtl/fifo_read_arbiter_pkg.sv
// Shared definitions for the FWFT FIFO read arbiter: state encoding and width helper.
package fifo_read_arbiter_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    BURST = 1'b1
  } arb_state_e;

  // Wide enough for any legal GAPMAX (1..15).
  localparam int unsigned GAP_CNT_W = 4;

  function automatic int unsigned clog2(input int unsigned n);
    int unsigned r;
    int unsigned v;
    r = 0;
    v = 1;
    while (v < n) begin
      v = v << 1;
      r++;
    end
    return r;
  endfunction

endpackage

// File: rtl/fifo_rr_pick.sv
// Combinational round-robin picker: first set bit of req at or above rr_ptr, wrapping.
module fifo_rr_pick #(
  parameter int unsigned NCH = 4,
  parameter int unsigned CW  = 2
) (
  input  logic [NCH-1:0] req,
  input  logic [CW-1:0]  rr_ptr,
  output logic [CW-1:0]  gnt_idx,
  output logic           any
);

  localparam logic [CW:0] NchW = (CW+1)'(NCH);

  logic [CW:0] w_idx;

  always_comb begin
    gnt_idx = '0;
    any     = 1'b0;
    w_idx   = '0;
    for (int unsigned k = 0; k < NCH; k++) begin
      // One extra bit so the wrap is a single conditional subtract.
      w_idx = {1'b0, rr_ptr} + (CW+1)'(k);
      if (w_idx >= NchW) begin
        w_idx = w_idx - NchW;
      end
      if (!any && req[w_idx[CW-1:0]]) begin
        any     = 1'b1;
        gnt_idx = w_idx[CW-1:0];
      end
    end
  end

endmodule

// File: rtl/fifo_read_arbiter.sv
// Round-robin burst arbiter merging NCH FWFT FIFO read ports into one valid/ready stream.
module fifo_read_arbiter
  import fifo_read_arbiter_pkg::*;
#(
  parameter int unsigned NCH      = 4,
  parameter int unsigned DWIDTH   = 32,
  parameter int unsigned MAXBURST = 8,
  parameter int unsigned GAPMAX   = 2
) (
  input  logic                    r_clk,
  input  logic                    r_rst_n,
  input  logic [NCH-1:0]          ch_en,
  input  logic [NCH-1:0]          ch_valid,
  input  logic [NCH*DWIDTH-1:0]   ch_dout,
  output logic [NCH-1:0]          ch_ren,
  output logic                    m_valid,
  input  logic                    m_ready,
  output logic [DWIDTH-1:0]       m_data,
  output logic [clog2(NCH)-1:0]   m_chan,
  output logic                    m_last,
  output logic                    busy
);

  localparam int unsigned CW = clog2(NCH);
  localparam int unsigned BW = clog2(MAXBURST + 1);

  localparam logic [BW-1:0]        LastBeat = BW'(MAXBURST - 1);
  localparam logic [GAP_CNT_W-1:0] GapEnd   = GAP_CNT_W'(GAPMAX);
  localparam logic [CW-1:0]        LastChan = CW'(NCH - 1);

  arb_state_e           r_state, w_state_d;
  logic [CW-1:0]        r_gnt, w_gnt_d;
  logic [CW-1:0]        r_rr_ptr, w_rr_ptr_d;
  logic [BW-1:0]        r_beat_cnt, w_beat_cnt_d;
  logic [GAP_CNT_W-1:0] r_gap_cnt, w_gap_cnt_d;

  logic [NCH-1:0]    w_req;
  logic [CW-1:0]     w_pick_idx;
  logic              w_pick_any;
  logic              w_sel_valid;
  logic [DWIDTH-1:0] w_sel_data;
  logic              w_in_burst;
  logic              w_accept;
  logic              w_last_beat;
  logic              w_gap_end;

  assign w_req = ch_en & ch_valid;

  fifo_rr_pick #(
    .NCH (NCH),
    .CW  (CW)
  ) u_rr_pick (
    .req     (w_req),
    .rr_ptr  (r_rr_ptr),
    .gnt_idx (w_pick_idx),
    .any     (w_pick_any)
  );

  always_comb begin
    w_sel_valid = 1'b0;
    w_sel_data  = '0;
    for (int unsigned i = 0; i < NCH; i++) begin
      if (r_gnt == CW'(i)) begin
        w_sel_valid = ch_valid[i];
        w_sel_data  = ch_dout[i*DWIDTH +: DWIDTH];
      end
    end
  end

  // Gating with reset keeps every output quiet during reset, even mid-burst.
  assign w_in_burst  = (r_state == BURST) && r_rst_n;
  assign m_valid     = w_in_burst && w_sel_valid;
  assign m_data      = w_in_burst ? w_sel_data : '0;
  assign m_chan      = w_in_burst ? r_gnt : '0;
  assign busy        = w_in_burst;
  assign w_accept    = m_valid && m_ready;
  assign w_last_beat = (r_beat_cnt == LastBeat);
  assign m_last      = m_valid && w_last_beat;
  // Only fires while m_valid is low, so a stalled beat is never withdrawn.
  assign w_gap_end   = !w_sel_valid && ((r_gap_cnt + GAP_CNT_W'(1)) == GapEnd);

  always_comb begin
    ch_ren = '0;
    for (int unsigned i = 0; i < NCH; i++) begin
      if (r_gnt == CW'(i)) begin
        ch_ren[i] = w_accept;
      end
    end
  end

  always_comb begin
    w_state_d    = r_state;
    w_gnt_d      = r_gnt;
    w_rr_ptr_d   = r_rr_ptr;
    w_beat_cnt_d = r_beat_cnt;
    w_gap_cnt_d  = r_gap_cnt;
    unique case (r_state)
      IDLE: begin
        if (w_pick_any) begin
          w_state_d    = BURST;
          w_gnt_d      = w_pick_idx;
          w_beat_cnt_d = '0;
          w_gap_cnt_d  = '0;
        end
      end
      BURST: begin
        if (w_accept) begin
          w_beat_cnt_d = r_beat_cnt + BW'(1);
        end
        w_gap_cnt_d = w_sel_valid ? '0 : r_gap_cnt + GAP_CNT_W'(1);
        if ((w_accept && w_last_beat) || w_gap_end) begin
          w_state_d  = IDLE;
          w_rr_ptr_d = (r_gnt == LastChan) ? '0 : r_gnt + CW'(1);
        end
      end
      default: w_state_d = IDLE;
    endcase
  end

  always_ff @(posedge r_clk) begin
    if (!r_rst_n) begin
      r_state    <= IDLE;
      r_gnt      <= '0;
      r_rr_ptr   <= '0;
      r_beat_cnt <= '0;
      r_gap_cnt  <= '0;
    end else begin
      r_state    <= w_state_d;
      r_gnt      <= w_gnt_d;
      r_rr_ptr   <= w_rr_ptr_d;
      r_beat_cnt <= w_beat_cnt_d;
      r_gap_cnt  <= w_gap_cnt_d;
    end
  end

endmodule

// File: tb/tb_fifo_read_arbiter.sv
// Self-checking bench for fifo_read_arbiter: directed vector table, burst sequences,
// and randomized traffic against a behavioural model.
module tb_fifo_read_arbiter;

  localparam int NCH  = 4;
  localparam int DW   = 32;
  localparam int MAXB = 8;
  localparam int GAPM = 2;

  logic              r_clk;
  logic              r_rst_n;
  logic [NCH-1:0]    ch_en;
  logic [NCH-1:0]    ch_valid;
  logic [NCH*DW-1:0] ch_dout;
  logic [NCH-1:0]    ch_ren;
  logic              m_valid;
  logic              m_ready;
  logic [DW-1:0]     m_data;
  logic [1:0]        m_chan;
  logic              m_last;
  logic              busy;

  fifo_read_arbiter #(
    .NCH      (NCH),
    .DWIDTH   (DW),
    .MAXBURST (MAXB),
    .GAPMAX   (GAPM)
  ) dut (
    .r_clk    (r_clk),
    .r_rst_n  (r_rst_n),
    .ch_en    (ch_en),
    .ch_valid (ch_valid),
    .ch_dout  (ch_dout),
    .ch_ren   (ch_ren),
    .m_valid  (m_valid),
    .m_ready  (m_ready),
    .m_data   (m_data),
    .m_chan   (m_chan),
    .m_last   (m_last),
    .busy     (busy)
  );

  initial r_clk = 1'b0;
  always #5 r_clk = ~r_clk;

  int checks = 0;
  int errors = 0;

  // Behavioural model: who owns the stream, how many beats taken, how many empty cycles.
  bit md_busy = 0;
  int md_g    = 0;
  int md_ptr  = 0;
  int md_beats = 0;
  int md_gaps  = 0;

  logic          s_valid, s_last, s_busy;
  logic [1:0]    s_chan;
  logic [3:0]    s_ren;
  logic [DW-1:0] s_data;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [DW-1:0] pat(input int i);
    return 32'hC0DE_0000 + DW'(i);
  endfunction

  task automatic model_update();
    bit acc;
    logic [NCH-1:0] req;
    if (!r_rst_n) begin
      md_busy = 0; md_g = 0; md_ptr = 0; md_beats = 0; md_gaps = 0;
    end else if (!md_busy) begin
      req = ch_en & ch_valid;
      if (req != 0) begin
        for (int k = 0; k < NCH; k++) begin
          if (!md_busy && req[(md_ptr + k) % NCH]) begin
            md_g    = (md_ptr + k) % NCH;
            md_busy = 1;
          end
        end
        md_beats = 0;
        md_gaps  = 0;
      end
    end else begin
      acc = ch_valid[md_g] && m_ready;
      if (acc) md_beats++;
      if (ch_valid[md_g]) md_gaps = 0;
      else md_gaps++;
      if ((acc && md_beats == MAXB) || md_gaps == GAPM) begin
        md_busy = 0;
        md_ptr  = (md_g + 1) % NCH;
      end
    end
  endtask

  // Sample on the falling edge, compare with the model, then advance one clock.
  task automatic tick();
    logic          e_busy, e_valid, e_last;
    logic [1:0]    e_chan;
    logic [3:0]    e_ren;
    logic [DW-1:0] e_data;
    @(negedge r_clk);
    s_valid = m_valid; s_last = m_last; s_busy = busy;
    s_chan = m_chan; s_ren = ch_ren; s_data = m_data;
    e_busy  = r_rst_n && md_busy;
    e_valid = e_busy && ch_valid[md_g];
    e_data  = e_busy ? ch_dout[md_g*DW +: DW] : '0;
    e_chan  = e_busy ? 2'(md_g) : 2'd0;
    e_last  = e_valid && (md_beats == MAXB - 1);
    e_ren   = (e_valid && m_ready) ? 4'(1 << md_g) : 4'd0;
    chk("model", 64'({s_valid, s_last, s_busy, s_chan, s_ren, s_data}),
        64'({e_valid, e_last, e_busy, e_chan, e_ren, e_data}));
    @(posedge r_clk);
    model_update();
    #1;
  endtask

  typedef struct {
    logic       rst_n;
    logic [3:0] en;
    logic [3:0] valid;
    logic       ready;
    logic       e_busy;
    logic       e_valid;
    logic [1:0] e_chan;
    logic       e_last;
    logic [3:0] e_ren;
  } vec_t;

  vec_t vecs[$];

  int grants[$];
  int lens[$];
  int lastpos[$];
  int idles[$];

  initial begin
    bit prev_busy;
    bit seen;
    int beats;
    int idle_run;
    logic [DW-1:0] e_data;

    // Gap end, stall, enable masking, mid-burst reset; starts with a reset row.
    vecs.push_back('{1'b0, 4'hF, 4'h0, 1'b1, 1'b0, 1'b0, 2'd0, 1'b0, 4'h0});
    vecs.push_back('{1'b1, 4'hF, 4'h4, 1'b1, 1'b0, 1'b0, 2'd0, 1'b0, 4'h0});
    for (int i = 0; i < 3; i++)
      vecs.push_back('{1'b1, 4'hF, 4'h4, 1'b1, 1'b1, 1'b1, 2'd2, 1'b0, 4'h4});
    for (int i = 0; i < 2; i++)
      vecs.push_back('{1'b1, 4'hF, 4'h0, 1'b1, 1'b1, 1'b0, 2'd2, 1'b0, 4'h0});
    vecs.push_back('{1'b1, 4'hF, 4'h0, 1'b1, 1'b0, 1'b0, 2'd0, 1'b0, 4'h0});
    vecs.push_back('{1'b1, 4'hF, 4'h1, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 4'h0});
    vecs.push_back('{1'b1, 4'hF, 4'h1, 1'b1, 1'b1, 1'b1, 2'd0, 1'b0, 4'h1});
    vecs.push_back('{1'b1, 4'hF, 4'h1, 1'b0, 1'b1, 1'b1, 2'd0, 1'b0, 4'h0});
    vecs.push_back('{1'b1, 4'hF, 4'h1, 1'b0, 1'b1, 1'b1, 2'd0, 1'b0, 4'h0});
    vecs.push_back('{1'b1, 4'hF, 4'h1, 1'b1, 1'b1, 1'b1, 2'd0, 1'b0, 4'h1});
    for (int i = 0; i < 2; i++)
      vecs.push_back('{1'b1, 4'hF, 4'h0, 1'b1, 1'b1, 1'b0, 2'd0, 1'b0, 4'h0});
    vecs.push_back('{1'b1, 4'hD, 4'h3, 1'b1, 1'b0, 1'b0, 2'd0, 1'b0, 4'h0});
    for (int i = 0; i < 7; i++)
      vecs.push_back('{1'b1, 4'hC, 4'h3, 1'b1, 1'b1, 1'b1, 2'd0, 1'b0, 4'h1});
    vecs.push_back('{1'b1, 4'hC, 4'h3, 1'b1, 1'b1, 1'b1, 2'd0, 1'b1, 4'h1});
    for (int i = 0; i < 2; i++)
      vecs.push_back('{1'b1, 4'hC, 4'h3, 1'b1, 1'b0, 1'b0, 2'd0, 1'b0, 4'h0});
    vecs.push_back('{1'b1, 4'hF, 4'hF, 1'b1, 1'b0, 1'b0, 2'd0, 1'b0, 4'h0});
    for (int i = 0; i < 3; i++)
      vecs.push_back('{1'b1, 4'hF, 4'hF, 1'b1, 1'b1, 1'b1, 2'd1, 1'b0, 4'h2});
    vecs.push_back('{1'b0, 4'hF, 4'hF, 1'b1, 1'b0, 1'b0, 2'd0, 1'b0, 4'h0});
    vecs.push_back('{1'b1, 4'hF, 4'h9, 1'b1, 1'b0, 1'b0, 2'd0, 1'b0, 4'h0});
    vecs.push_back('{1'b1, 4'hF, 4'h9, 1'b1, 1'b1, 1'b1, 2'd0, 1'b0, 4'h1});

    r_rst_n = 1'b0; ch_en = '0; ch_valid = '0; m_ready = 1'b0;
    for (int i = 0; i < NCH; i++) ch_dout[i*DW +: DW] = pat(i);
    tick();
    tick();
    chk("reset_busy", 64'(s_busy), 64'd0);
    chk("reset_valid", 64'(s_valid), 64'd0);
    chk("reset_ren", 64'(s_ren), 64'd0);
    chk("reset_data", 64'(s_data), 64'd0);

    // All channels streaming, sink always ready.
    r_rst_n = 1'b1; ch_en = 4'hF; ch_valid = 4'hF; m_ready = 1'b1;
    prev_busy = 0; seen = 0; beats = 0; idle_run = 0;
    for (int c = 0; c < 46; c++) begin
      tick();
      if (s_busy && !prev_busy) begin
        grants.push_back(int'(s_chan));
        if (seen) idles.push_back(idle_run);
        beats = 0;
      end
      if (s_busy && s_ren != 0) begin
        beats++;
        if (s_last) lastpos.push_back(beats);
      end
      if (!s_busy && prev_busy) begin
        lens.push_back(beats);
        seen = 1;
        idle_run = 0;
      end
      if (!s_busy) idle_run++;
      prev_busy = s_busy;
    end
    chk("rr_grant_count", 64'(grants.size()), 64'd5);
    chk("rr_burst_count", 64'(lens.size()), 64'd5);
    chk("rr_last_count", 64'(lastpos.size()), 64'd5);
    chk("rr_idle_count", 64'(idles.size()), 64'd4);
    for (int i = 0; i < grants.size() && i < 5; i++) chk("rr_grant_order", 64'(grants[i]), 64'(i % NCH));
    for (int i = 0; i < lens.size(); i++) chk("rr_burst_len", 64'(lens[i]), 64'(MAXB));
    for (int i = 0; i < lastpos.size(); i++) chk("rr_last_pos", 64'(lastpos[i]), 64'(MAXB));
    for (int i = 0; i < idles.size(); i++) chk("rr_idle_gap", 64'(idles[i]), 64'd1);

    foreach (vecs[i]) begin
      r_rst_n = vecs[i].rst_n; ch_en = vecs[i].en;
      ch_valid = vecs[i].valid; m_ready = vecs[i].ready;
      tick();
      e_data = vecs[i].e_busy ? pat(int'(vecs[i].e_chan)) : '0;
      chk($sformatf("vec%0d", i), 64'({s_busy, s_valid, s_chan, s_last, s_ren, s_data}),
          64'({vecs[i].e_busy, vecs[i].e_valid, vecs[i].e_chan, vecs[i].e_last,
               vecs[i].e_ren, e_data}));
    end

    // Random traffic with occasional reset; the model checks every cycle.
    for (int c = 0; c < 2000; c++) begin
      r_rst_n = ($urandom_range(299, 0) != 0);
      for (int i = 0; i < NCH; i++) begin
        ch_en[i]    = ($urandom_range(99, 0) < 80);
        ch_valid[i] = ($urandom_range(99, 0) < 70);
        ch_dout[i*DW +: DW] = $urandom();
      end
      m_ready = ($urandom_range(99, 0) < 75);
      tick();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
